// File: rtl/uart_pkg.sv
// Shared register map, CON bit positions and TX sequencer state encodings
// for the UART bus controller.
package uart_pkg;

   localparam logic [31:0] TXD_OFF = 32'h0000_0000;
   localparam logic [31:0] RXD_OFF = 32'h0000_0004;
   localparam logic [31:0] CON_OFF = 32'h0000_0008;

   localparam int CON_TX_IRQ_EN  = 0;
   localparam int CON_RX_IRQ_EN  = 1;
   localparam int CON_TX_EMPTY   = 2;
   localparam int CON_RX_NEMPTY  = 3;
   localparam int CON_TX_OVF     = 4;
   localparam int CON_RX_OVR     = 5;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_REQ  = 2'd1,
      TX_BUSY = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO, head visible combinationally on dout; push/pop commit at the edge.
// A pop on a full FIFO frees the slot for a same-cycle push; a pop on empty is ignored.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART front end: TX/RX FIFOs, CON register and TX handshake sequencer.
// Reads are combinational; a full TX FIFO drops writes (tx_overflow), a full RX FIFO drops bytes (rx_overrun).
module uart_bus_ctrl
   import uart_pkg::*;
#(
   parameter int          DEPTH = 4,
   parameter logic [31:0] BASE  = 32'h4000_0018
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [7:0]  tx_data,
   output logic        tx_ctrl,
   input  logic        tx_status,
   input  logic [7:0]  rx_data,
   input  logic        rx_status
);
   localparam int CW = $clog2(DEPTH) + 1;

   tx_state_e     state_q, state_d;
   logic [1:0]    irq_en_q, irq_en_d;
   logic          tx_ovf_q, tx_ovf_d;
   logic          rx_ovr_q, rx_ovr_d;
   logic          rx_prev_q;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          hit_txd, hit_rxd, hit_con;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    tx_head, rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic [31:0]   con_val;
   logic          unused_ok;

   assign hit_txd = (addr == BASE + TXD_OFF);
   assign hit_rxd = (addr == BASE + RXD_OFF);
   assign hit_con = (addr == BASE + CON_OFF);

   assign tx_push = mem_write & hit_txd;
   assign rx_pop  = mem_read & hit_rxd;
   assign rx_push = rx_status & ~rx_prev_q;

   uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk(sysclk), .rst_n(reset), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk(sysclk), .rst_n(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
      .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   // Clear-on-read applies first so a set event in the same cycle survives.
   always_comb begin
      irq_en_d = (mem_write && hit_con) ? wdata[1:0] : irq_en_q;
      tx_ovf_d = (tx_ovf_q & ~(mem_read & hit_con)) | (tx_push & tx_full & ~tx_pop);
      rx_ovr_d = (rx_ovr_q & ~(mem_read & hit_con)) | (rx_push & rx_full & ~rx_pop);
   end

   always_comb begin
      con_val                = '0;
      con_val[CON_TX_IRQ_EN] = irq_en_q[0];
      con_val[CON_RX_IRQ_EN] = irq_en_q[1];
      con_val[CON_TX_EMPTY]  = tx_empty;
      con_val[CON_RX_NEMPTY] = ~rx_empty;
      con_val[CON_TX_OVF]    = tx_ovf_q;
      con_val[CON_RX_OVR]    = rx_ovr_q;
   end

   always_comb begin
      rdata = '0;
      if (mem_read) begin
         if (hit_rxd && !rx_empty) begin
            rdata = {24'b0, rx_head};
         end else if (hit_con) begin
            rdata = con_val;
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q   <= TX_IDLE;
         irq_en_q  <= '0;
         tx_ovf_q  <= 1'b0;
         rx_ovr_q  <= 1'b0;
         rx_prev_q <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         irq_en_q  <= irq_en_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_ovr_q  <= rx_ovr_d;
         rx_prev_q <= rx_status;
         tx_data_q <= tx_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TX_IDLE: if (!tx_empty && tx_status) state_d = TX_REQ;
         TX_REQ:  if (!tx_status)             state_d = TX_BUSY;
         TX_BUSY: if (tx_status)              state_d = TX_IDLE;
         default:                             state_d = TX_IDLE;
      endcase
   end

   // The byte is latched on entry to REQ and held until the next send starts.
   always_comb begin
      tx_ctrl   = (state_q == TX_REQ);
      tx_pop    = (state_q == TX_BUSY) && tx_status;
      tx_data_d = ((state_q == TX_IDLE) && (state_d == TX_REQ)) ? tx_head : tx_data_q;
   end

   assign tx_data   = tx_data_q;
   assign irq       = (irq_en_q[1] & ~rx_empty) |
                      (irq_en_q[0] & tx_empty & (state_q == TX_IDLE));
   assign unused_ok = ^{tx_count, rx_count, wdata[31:8]};

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: register map, TX handshake, RX edge capture, FIFO limits, reset.
module tb_uart_bus_ctrl;
   import uart_pkg::*;

   localparam logic [31:0] BASE  = 32'h4000_0018;
   localparam logic [31:0] A_TXD = BASE + TXD_OFF;
   localparam logic [31:0] A_RXD = BASE + RXD_OFF;
   localparam logic [31:0] A_CON = BASE + CON_OFF;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic        mem_read, mem_write, irq;
   logic [7:0]  tx_data, rx_data;
   logic        tx_ctrl, tx_status, rx_status;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] d;
   int          hi, n;
   logic        data_ok;
   logic [7:0]  exp_rx [4];

   uart_bus_ctrl #(.DEPTH(4), .BASE(BASE)) dut (
      .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata), .irq(irq),
      .tx_data(tx_data), .tx_ctrl(tx_ctrl), .tx_status(tx_status),
      .rx_data(rx_data), .rx_status(rx_status)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
      addr = a; wdata = v; mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      addr = a; mem_read = 1'b1;
      #1 v = rdata;
      tick();
      mem_read = 1'b0;
   endtask

   // Combinational look without letting an edge see mem_read, so nothing pops or clears.
   task automatic peek(input logic [31:0] a, output logic [31:0] v);
      addr = a; mem_read = 1'b1;
      #1 v = rdata;
      mem_read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
      tx_status = 1'b1; rx_data = '0; rx_status = 1'b0;
      repeat (3) tick();
      chk("rst_tx_ctrl", 32'(tx_ctrl), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      peek(A_CON, d); chk("rst_con", d, 32'h4);
      reset = 1'b1;
      tick();

      // Single byte through the sender handshake
      bus_write(A_TXD, 32'h55);
      chk("t1_ctrl_idle", 32'(tx_ctrl), 32'h0);
      tick();
      hi = 0; data_ok = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (tx_ctrl) hi++;
         if (c <= 22 && tx_data !== 8'h55) data_ok = 1'b0;
         if (c == 2) tx_status = 1'b0;
         if (c == 22) begin
            peek(A_CON, d); chk("t1_con_before_rise", d, 32'h0);
            tx_status = 1'b1;
         end
         if (c == 23) begin
            peek(A_CON, d); chk("t1_con_after_rise", d, 32'h4);
         end
         tick();
      end
      chk("t1_ctrl_cycles", 32'(hi), 32'd3);
      chk("t1_data_stable", 32'(data_ok), 32'h1);

      // TX overflow and in-order delivery
      tx_status = 1'b0;
      for (int k = 1; k <= 5; k++) bus_write(A_TXD, 32'(k));
      peek(A_CON, d); chk("t2_con_ovf", d, 32'h10);
      tx_status = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n = 0;
         while (!tx_ctrl && n < 10) begin tick(); n++; end
         chk($sformatf("t2_ctrl%0d", k), 32'(tx_ctrl), 32'h1);
         chk($sformatf("t2_byte%0d", k), 32'(tx_data), 32'(k));
         tx_status = 1'b0; tick(); tick();
         tx_status = 1'b1; tick();
      end
      hi = 0;
      repeat (6) begin if (tx_ctrl) hi++; tick(); end
      chk("t2_no_fifth", 32'(hi), 32'd0);
      bus_read(A_CON, d); chk("t2_con_read", d, 32'h14);
      peek(A_CON, d); chk("t2_con_cleared", d, 32'h4);

      // Long rx_status pulse yields one byte
      bus_write(A_CON, 32'h2);
      chk("t3_irq_pre", 32'(irq), 32'h0);
      rx_data = 8'hA3; rx_status = 1'b1;
      tick();
      chk("t3_irq_rx", 32'(irq), 32'h1);
      repeat (5) tick();
      rx_status = 1'b0;
      tick();
      peek(A_CON, d); chk("t3_con_nonempty", d, 32'hE);
      bus_read(A_RXD, d); chk("t3_rxd", d, 32'h0000_00A3);
      peek(A_CON, d); chk("t3_con_empty", d, 32'h6);
      chk("t3_irq_post", 32'(irq), 32'h0);
      bus_read(A_RXD, d); chk("t3_rxd_empty", d, 32'h0);

      // Same-cycle CON read and write: read sees the old value
      addr = A_CON; wdata = 32'h1; mem_read = 1'b1; mem_write = 1'b1;
      #1 d = rdata;
      chk("t3_rw_old", d, 32'h6);
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      peek(A_CON, d); chk("t3_rw_new", d, 32'h5);
      chk("t3_irq_tx", 32'(irq), 32'h1);
      bus_write(A_CON, 32'h0);
      chk("t3_irq_off", 32'(irq), 32'h0);

      // RX overrun and clear-on-read
      for (int k = 0; k < 5; k++) begin
         rx_data = 8'h10 + 8'(k); rx_status = 1'b1; tick();
         rx_status = 1'b0; tick();
      end
      peek(A_CON, d); chk("t4_con_ovr", d, 32'h2C);
      bus_read(A_CON, d); chk("t4_con_read", d, 32'h2C);
      peek(A_CON, d); chk("t4_con_cleared", d, 32'h0C);

      // Full RX FIFO: a pop in the same cycle makes room for the new byte
      addr = A_RXD; mem_read = 1'b1; rx_data = 8'h77; rx_status = 1'b1;
      #1 d = rdata;
      chk("t5_oldest", d, 32'h10);
      tick();
      mem_read = 1'b0; rx_status = 1'b0;
      peek(A_CON, d); chk("t5_no_ovr", d, 32'h0C);
      exp_rx[0] = 8'h11; exp_rx[1] = 8'h12; exp_rx[2] = 8'h13; exp_rx[3] = 8'h77;
      for (int k = 0; k < 4; k++) begin
         bus_read(A_RXD, d); chk($sformatf("t5_rx%0d", k), d, 32'(exp_rx[k]));
      end
      peek(A_CON, d); chk("t5_con_drained", d, 32'h4);

      // Reset while the sender is busy with two bytes queued
      bus_write(A_CON, 32'h2);
      rx_data = 8'h5A; rx_status = 1'b1; tick();
      rx_status = 1'b0;
      tx_status = 1'b0;
      bus_write(A_TXD, 32'hA1);
      bus_write(A_TXD, 32'hA2);
      tx_status = 1'b1; tick();
      chk("t6_req", 32'(tx_ctrl), 32'h1);
      tx_status = 1'b0; tick(); tick();
      chk("t6_busy_data", 32'(tx_data), 32'hA1);
      chk("t6_irq_pre", 32'(irq), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_ctrl", 32'(tx_ctrl), 32'h0);
      chk("t6_rst_data", 32'(tx_data), 32'h0);
      chk("t6_rst_irq", 32'(irq), 32'h0);
      peek(A_CON, d); chk("t6_rst_con", d, 32'h4);
      tx_status = 1'b1;
      tick(); tick();
      reset = 1'b1;
      hi = 0;
      repeat (20) begin if (tx_ctrl) hi++; tick(); end
      chk("t6_nothing_sent", 32'(hi), 32'd0);
      peek(A_CON, d); chk("t6_con_final", d, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO (power of 2, 2..16).
REQ-002 SHALL have parameter BASE, default 32'h40000018, meaning the address of TXD; RXD is at BASE+4 and CON at BASE+8.
REQ-003 SHALL have port sysclk  in  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have ports addr  in  32, wdata  in  32, mem_read  in  1 and mem_write  in  1, meaning the CPU data-bus request.
REQ-006 SHALL have port rdata  out  32  meaning the combinational read data, zero when there is no register hit or mem_read=0.
REQ-007 SHALL have port irq  out  1  meaning the level interrupt to the CPU.
REQ-008 SHALL have port tx_data  out  8  meaning the byte presented to the UART sender.
REQ-009 SHALL have port tx_ctrl  out  1  meaning the send request to the sender.
REQ-010 SHALL have port tx_status  in  1  meaning sender idle (1) or busy (0).
REQ-011 SHALL have ports rx_data  in  8 and rx_status  in  1, meaning the received byte and its valid indication (a pulse of one or more cycles).

Function
REQ-012 SHALL, on mem_write to TXD, push wdata[7:0] into the TX FIFO when it is not full; a write while the FIFO is full is dropped and sets CON[4] (tx_overflow).
REQ-013 SHALL, on mem_read of RXD, return {24'b0, RX head} combinationally and pop at the clock edge; reading while the FIFO is empty returns 0 and pops nothing.
REQ-014 SHALL define CON as: [0] tx_irq_en (RW), [1] rx_irq_en (RW), [2] tx_fifo_empty (RO), [3] rx_fifo_nonempty (RO), [4] tx_overflow (sticky), [5] rx_overrun (sticky), [31:6] reads 0.
REQ-015 SHALL, on a CON write, update bits [1:0] only; a CON read clears bits [5:4] at that edge, and a new set event in the same cycle wins.
REQ-016 SHALL run the TX FSM with states IDLE, REQ, BUSY.
REQ-017 SHALL go IDLE->REQ when the TX FIFO is non-empty and tx_status=1; tx_data = TX head from that cycle on.
REQ-018 SHALL assert tx_ctrl=1 only in REQ, and go REQ->BUSY on the first cycle tx_status=0.
REQ-019 SHALL go BUSY->IDLE on the first cycle tx_status=1, popping the TX head in that same cycle; tx_data is held stable for all of REQ and BUSY.
REQ-020 SHALL detect the rising edge of rx_status using a registered previous value; each edge pushes rx_data exactly once, with 1-cycle latency to nonempty.
REQ-021 SHALL drop the byte when the RX FIFO is full at the edge and set rx_overrun, except that a same-cycle RXD pop makes room and the push succeeds.
REQ-022 SHALL let a simultaneous push and pop on either FIFO both take effect, with count unchanged; on an empty FIFO the pop is ignored and the push is applied.
REQ-023 SHALL wrap read and write pointers modulo DEPTH and keep a count of width clog2(DEPTH)+1 that never exceeds DEPTH or goes below 0.
REQ-024 SHALL drive irq = (rx_irq_en & rx_fifo_nonempty) | (tx_irq_en & tx_fifo_empty & TX FSM in IDLE).
REQ-025 SHALL treat a same-cycle mem_read and mem_write to the same register as: the write applies, the read returns the pre-write value, and a read-pop still occurs.

Reset
REQ-026 SHALL, while reset=0, immediately force: both FIFOs empty, pointers 0, TX FSM in IDLE, tx_ctrl=0, tx_data=0, CON[1:0]=0, sticky bits 0, rx_status history 0, irq=0.
REQ-027 SHALL discard an in-flight TX on reset assertion with no pop replay; after release, a byte the sender is still shifting is not re-sent.
REQ-028 SHALL not require any initial-block values; the reset defines all state.

Structure
REQ-029 SHALL place the register offsets (TXD/RXD/CON), CON bit indices and TX FSM state encodings in shared package uart_pkg.
REQ-030 SHALL implement both queues as one sub-module uart_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated twice.

Verification
REQ-031 SHALL cover: write TXD=0x55, with tx_status falling 3 cycles after tx_ctrl and rising 20 cycles later -> tx_ctrl high exactly 3 cycles, tx_data=0x55 throughout, pop at the rise, CON[2]=1.
REQ-032 SHALL cover: 5 TXD writes (0x01..0x05) with tx_status held 0 -> first 4 queued, CON[4]=1; after release, bytes are sent in order 0x01..0x04.
REQ-033 SHALL cover: rx_status pulse 6 cycles long with rx_data=0xA3 -> exactly one push; RXD read returns 0x000000A3, then CON[3]=0.
REQ-034 SHALL cover: 5 RX edges with no reads -> 4 bytes stored, CON[5]=1; a CON read clears it, and the next read shows 0.
REQ-035 SHALL cover: RX full, with an rx_status edge in the same cycle as an RXD read -> the read returns the oldest byte, the new byte is stored, and no overrun.
REQ-036 SHALL cover: reset pulled low mid-BUSY with 2 bytes queued -> tx_ctrl=0 and CON[2]=1 asynchronously, and after release nothing is sent.
